bcd_to_bin: RTL and testbench

//  Serial BCD-to-binary converter. Inverse of the team's 20-bit binary-to-BCD digit splitter.

---
 rtl/bcd_pkg.sv | 19 +
 rtl/bcd_nibble_sub3.sv | 12 +
 rtl/bcd_to_bin.sv | 131 +++++++++++++
 tb/tb_bcd_to_bin.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD <-> binary conversion blocks.
package bcd_pkg;

   localparam int BCD_DIGITS = 6;
   localparam int BIN_W      = 20;

   typedef logic [3:0] bcd_t;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   // A BCD nibble is only legal in the range 0..9.
   function automatic logic bcd_invalid(input bcd_t d);
      return (d > 4'd9);
   endfunction

endpackage

// File: rtl/bcd_nibble_sub3.sv
// One BCD column of the reverse double-dabble adjust: undo the +3 bias
// that a right shift leaves behind in any nibble that reached 8 or more.
module bcd_nibble_sub3
   import bcd_pkg::*;
(
   input  logic [3:0] in_nib,
   output logic [3:0] out_nib
);

   assign out_nib = (in_nib >= 4'd8) ? (in_nib - 4'd3) : in_nib;

endmodule

// File: rtl/bcd_to_bin.sv
// Serial BCD-to-binary converter (reverse double-dabble).
// The BCD digits are loaded into the top of a shift register and shifted
// right one bit per cycle; after each shift, every BCD nibble >= 8 has 3
// subtracted. After BIN_W iterations the low field holds the binary value.
module bcd_to_bin
   import bcd_pkg::*;
#(
   parameter int DIGITS = bcd_pkg::BCD_DIGITS,
   parameter int BIN_W  = bcd_pkg::BIN_W,
   parameter int CNT_W  = 5
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             start,
   input  logic [3:0]       unit,
   input  logic [3:0]       ten,
   input  logic [3:0]       hun,
   input  logic [3:0]       thou,
   input  logic [3:0]       t_thou,
   input  logic [3:0]       h_thou,
   output logic [BIN_W-1:0] data,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam int SR_W = 4*DIGITS + BIN_W;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W-1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [SR_W-1:0]   sr_q, sr_d;
   logic [BIN_W-1:0]  data_q, data_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              err_int_q, err_int_d;

   bcd_t [DIGITS-1:0] dig_in;
   logic              any_bad;
   logic [SR_W-1:0]   nx;
   logic [SR_W-1:0]   nx_adj;

   // Digits ordered most significant first so the packed array maps
   // straight onto the BCD field of the shift register.
   assign dig_in = {h_thou, t_thou, thou, hun, ten, unit};

   // Flag any non-decimal digit at the time the request is taken.
   always_comb begin
      any_bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         any_bad = any_bad | bcd_invalid(dig_in[i]);
      end
   end

   // One iteration: logical shift right, then per-nibble bias correction.
   assign nx = sr_q >> 1;
   assign nx_adj[BIN_W-1:0] = nx[BIN_W-1:0];

   for (genvar g = 0; g < DIGITS; g++) begin : g_nib
      bcd_nibble_sub3 u_sub3 (
         .in_nib  (nx[BIN_W + 4*g +: 4]),
         .out_nib (nx_adj[BIN_W + 4*g +: 4])
      );
   end

   // Next-state and register-input logic; done is a single-cycle pulse.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sr_d      = sr_q;
      data_d    = data_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      err_d     = err_q;
      err_int_d = err_int_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               sr_d      = {dig_in, {BIN_W{1'b0}}};
               cnt_d     = '0;
               busy_d    = 1'b1;
               err_int_d = any_bad;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            sr_d  = nx_adj;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ITER) begin
               // An invalid digit still runs full length so latency is fixed.
               data_d  = err_int_q ? '0 : nx_adj[BIN_W-1:0];
               err_d   = err_int_q;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset aborts any conversion in flight.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         sr_q      <= '0;
         data_q    <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         err_int_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sr_q      <= sr_d;
         data_q    <= data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         err_int_q <= err_int_d;
      end
   end

   assign data = data_q;
   assign busy = busy_q;
   assign done = done_q;
   assign err  = err_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Scoreboard bench for bcd_to_bin: expected results are queued when a
// request is accepted and compared when done pulses.
module tb_bcd_to_bin;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  unit = '0, ten = '0, hun = '0, thou = '0, t_thou = '0, h_thou = '0;
   logic [19:0] data;
   logic        busy, done, err;

   typedef struct {
      logic [19:0] val;
      logic        bad;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;

   bcd_to_bin dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .start     (start),
      .unit      (unit),
      .ten       (ten),
      .hun       (hun),
      .thou      (thou),
      .t_thou    (t_thou),
      .h_thou    (h_thou),
      .data      (data),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Decimal reference value of a packed {h_thou..unit} digit vector.
   function automatic exp_t model(input logic [23:0] d);
      exp_t e;
      int   v = 0;
      logic bad = 1'b0;
      logic [3:0] nib;
      for (int i = 5; i >= 0; i--) begin
         nib = d[4*i +: 4];
         if (nib > 4'd9) bad = 1'b1;
         v = v * 10 + int'(nib);
      end
      e.val = bad ? 20'd0 : v[19:0];
      e.bad = bad;
      e.cyc = 0;
      return e;
   endfunction

   function automatic logic [23:0] rand_legal();
      logic [23:0] d;
      for (int i = 0; i < 6; i++) d[4*i +: 4] = 4'($urandom_range(0, 9));
      return d;
   endfunction

   task automatic drive_digits(input logic [23:0] d);
      {h_thou, t_thou, thou, hun, ten, unit} = d;
   endtask

   // Called just after a falling edge; request is accepted at the next rising edge.
   task automatic send(input logic [23:0] d);
      exp_t e;
      drive_digits(d);
      start = 1'b1;
      @(posedge sys_clk);
      #1;
      e = model(d);
      e.cyc = cyc;
      sb.push_back(e);
      start = 1'b0;
      drive_digits(24'h000000);
   endtask

   // Returns at the falling edge where done is seen (monitor checks it there).
   task automatic wait_done(input string tag);
      bit seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge sys_clk);
         if (done) seen = 1;
      end
      if (!seen) chk({tag, "_timeout"}, 0, 1);
   endtask

   // Completion monitor.
   always @(negedge sys_clk) begin
      exp_t e;
      if (sys_rst_n && done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("data", 32'(data), 32'(e.val));
            chk("err", 32'(err), 32'(e.bad));
            chk("latency", cyc - e.cyc, 20);
            chk("busy_at_done", 32'(busy), 0);
         end
      end
   end

   initial begin
      // Reset state.
      #12;
      chk("rst_data", 32'(data), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      @(negedge sys_clk);

      // 1: maximum legal value.
      send(24'h999999);
      chk("busy_after_start", 32'(busy), 1);
      wait_done("t1");
      @(negedge sys_clk);
      chk("done_width_t1", 32'(done), 0);
      chk("hold_data_t1", 32'(data), 32'h000F423F);

      // 2: all zero.
      send(24'h000000);
      wait_done("t2");
      @(negedge sys_clk);
      chk("done_width_t2", 32'(done), 0);

      // 3: back-to-back, second start accepted right after done.
      @(negedge sys_clk);
      send(24'h123456);
      wait_done("t3a");
      send(24'h000042);
      wait_done("t3b");

      // 4: invalid digit, then a legal request clears err.
      @(negedge sys_clk);
      send(24'h0000A0);
      wait_done("t4a");
      @(negedge sys_clk);
      chk("err_hold", 32'(err), 1);
      send(24'h000507);
      wait_done("t4b");

      // 5: start re-pulsed while busy is ignored.
      @(negedge sys_clk);
      send(24'h314159);
      repeat (4) @(negedge sys_clk);
      drive_digits(24'h888888);
      start = 1'b1;
      @(negedge sys_clk);
      start = 1'b0;
      drive_digits(24'h777777);
      wait_done("t5");
      repeat (3) @(negedge sys_clk);
      chk("t5_no_second_done", 32'(sb.size()), 0);

      // 6: reset mid-conversion.
      send(24'h654321);
      repeat (9) @(negedge sys_clk);
      sys_rst_n = 1'b0;
      #1;
      chk("midrst_data", 32'(data), 0);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_done", 32'(done), 0);
      chk("midrst_err", 32'(err), 0);
      void'(sb.pop_back());
      repeat (3) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      for (int i = 0; i < 25; i++) begin
         @(negedge sys_clk);
         if (done) chk("done_after_abort", 1, 0);
      end
      send(24'h020406);
      wait_done("t6");

      // Random legal vectors, alternating gapped and back-to-back.
      for (int n = 0; n < 24; n++) begin
         if (n % 2 == 0) @(negedge sys_clk);
         send(rand_legal());
         wait_done("rnd");
      end

      repeat (3) @(negedge sys_clk);
      chk("sb_empty", 32'(sb.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   // Global time limit.
   initial begin
      #200000;
      n_fail++;
      $display("FAIL global_timeout: simulation did not complete");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $fatal(1);
   end

endmodule
